// File: rtl/rr_decode_if.sv
// Handshake bundle between fetch, the RV32I decode stage, register read and writeback.
// The slave modport is the decode stage; the master modport is whatever surrounds it.
interface rr_decode_if #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
);
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [31:0]       in_inst;
  logic [XLEN-1:0]   in_pc;
  logic              out_valid;
  logic              out_ready;
  logic [REG_AW-1:0] out_rs1;
  logic [REG_AW-1:0] out_rs2;
  logic [REG_AW-1:0] out_rd;
  logic [XLEN-1:0]   out_imm;
  logic [XLEN-1:0]   out_pc;
  logic [1:0]        out_pc_sel;
  logic [1:0]        out_a_sel;
  logic              out_b_sel;
  logic              out_illegal;
  logic              wb_valid;
  logic [REG_AW-1:0] wb_rd;

  modport master (
    output flush, in_valid, in_inst, in_pc, out_ready, wb_valid, wb_rd,
    input  in_ready, out_valid, out_rs1, out_rs2, out_rd, out_imm, out_pc,
           out_pc_sel, out_a_sel, out_b_sel, out_illegal
  );

  modport slave (
    input  flush, in_valid, in_inst, in_pc, out_ready, wb_valid, wb_rd,
    output in_ready, out_valid, out_rs1, out_rs2, out_rd, out_imm, out_pc,
           out_pc_sel, out_a_sel, out_b_sel, out_illegal
  );
endinterface

// File: rtl/rr_decode_stage.sv
// Registered RV32I decode stage with a one-entry output register and a
// register busy scoreboard that holds issue on read-after-write hazards.
module rr_decode_stage #(
  parameter int XLEN          = 32,
  parameter int REG_AW        = 5,
  parameter int SCOREBOARD_EN = 1
) (
  input logic         clock,
  input logic         reset,
  rr_decode_if.slave  bus
);
  localparam int NREG = 2 ** REG_AW;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  localparam logic [1:0] PC_PLUS_4 = 2'd0;
  localparam logic [1:0] PC_JAL    = 2'd1;
  localparam logic [1:0] PC_JALR   = 2'd2;
  localparam logic [1:0] PC_BRANCH = 2'd3;
  localparam logic [1:0] A_REG     = 2'd0;
  localparam logic [1:0] A_PC      = 2'd1;
  localparam logic [1:0] A_0       = 2'd2;
  localparam logic       B_REG     = 1'b0;
  localparam logic       B_IMM     = 1'b1;

  function automatic logic signed [XLEN-1:0] sext32(input logic signed [31:0] v);
    return XLEN'(v);
  endfunction

  function automatic logic [REG_AW-1:0] reg_idx(input logic [4:0] f);
    return REG_AW'(f);
  endfunction

  // ---- stage p0: combinational decode of the offered instruction ----
  logic [31:0]              inst_p0;
  logic [6:0]               opc_p0;
  logic                     use_rs1_p0, use_rs2_p0, use_rd_p0;
  logic [REG_AW-1:0]        rs1_p0, rs2_p0, rd_p0;
  logic signed [XLEN-1:0]   imm_i_p0, imm_s_p0, imm_b_p0, imm_u_p0, imm_j_p0, shamt_p0;
  logic signed [XLEN-1:0]   imm_p0;
  logic [1:0]               pc_sel_p0, a_sel_p0;
  logic                     b_sel_p0, ill_p0;

  assign inst_p0  = bus.in_inst;
  assign opc_p0   = inst_p0[6:0];
  assign imm_i_p0 = sext32({{20{inst_p0[31]}}, inst_p0[31:20]});
  assign imm_s_p0 = sext32({{20{inst_p0[31]}}, inst_p0[31:25], inst_p0[11:7]});
  assign imm_b_p0 = sext32({{20{inst_p0[31]}}, inst_p0[7], inst_p0[30:25], inst_p0[11:8], 1'b0});
  assign imm_u_p0 = sext32({inst_p0[31:12], 12'b0});
  assign imm_j_p0 = sext32({{12{inst_p0[31]}}, inst_p0[19:12], inst_p0[20], inst_p0[30:21], 1'b0});
  assign shamt_p0 = XLEN'(inst_p0[24:20]);

  always_comb begin
    use_rs1_p0 = 1'b0;
    use_rs2_p0 = 1'b0;
    use_rd_p0  = 1'b0;
    imm_p0     = '0;
    pc_sel_p0  = PC_PLUS_4;
    a_sel_p0   = A_REG;
    b_sel_p0   = B_REG;
    ill_p0     = 1'b0;
    case (opc_p0)
      OPC_OP: begin
        use_rs1_p0 = 1'b1; use_rs2_p0 = 1'b1; use_rd_p0 = 1'b1;
      end
      OPC_OP_IMM: begin
        use_rs1_p0 = 1'b1; use_rd_p0 = 1'b1; b_sel_p0 = B_IMM;
        // SLLI/SRLI/SRAI carry a shift amount, not a signed constant; funct7 is dropped
        imm_p0 = (inst_p0[13:12] == 2'b01) ? shamt_p0 : imm_i_p0;
      end
      OPC_LOAD: begin
        use_rs1_p0 = 1'b1; use_rd_p0 = 1'b1; b_sel_p0 = B_IMM; imm_p0 = imm_i_p0;
      end
      OPC_STORE: begin
        use_rs1_p0 = 1'b1; use_rs2_p0 = 1'b1; b_sel_p0 = B_IMM; imm_p0 = imm_s_p0;
      end
      OPC_BRANCH: begin
        use_rs1_p0 = 1'b1; use_rs2_p0 = 1'b1; pc_sel_p0 = PC_BRANCH; imm_p0 = imm_b_p0;
      end
      OPC_LUI: begin
        use_rd_p0 = 1'b1; a_sel_p0 = A_0; b_sel_p0 = B_IMM; imm_p0 = imm_u_p0;
      end
      OPC_AUIPC: begin
        use_rd_p0 = 1'b1; a_sel_p0 = A_PC; b_sel_p0 = B_IMM; imm_p0 = imm_u_p0;
      end
      OPC_JAL: begin
        use_rd_p0 = 1'b1; pc_sel_p0 = PC_JAL; a_sel_p0 = A_PC; b_sel_p0 = B_IMM;
        imm_p0 = imm_j_p0;
      end
      OPC_JALR: begin
        use_rs1_p0 = 1'b1; use_rd_p0 = 1'b1; pc_sel_p0 = PC_JALR; b_sel_p0 = B_IMM;
        imm_p0 = imm_i_p0;
      end
      default: ill_p0 = 1'b1;
    endcase
  end

  assign rs1_p0 = use_rs1_p0 ? reg_idx(inst_p0[19:15]) : '0;
  assign rs2_p0 = use_rs2_p0 ? reg_idx(inst_p0[24:20]) : '0;
  assign rd_p0  = use_rd_p0  ? reg_idx(inst_p0[11:7])  : '0;

  // ---- hazard check and handshake against the p1 output register ----
  logic                    vld_p1;
  logic [REG_AW-1:0]       rs1_p1, rs2_p1, rd_p1;
  logic signed [XLEN-1:0]  imm_p1;
  logic [XLEN-1:0]         pc_p1;
  logic [1:0]              pc_sel_p1, a_sel_p1;
  logic                    b_sel_p1, ill_p1;
  logic [NREG-1:0]         busy_q, busy_eff, busy_nxt, wb_clr;
  logic                    stall, in_ready, accept;

  // a writeback landing this cycle already frees its register for the hazard check
  assign wb_clr   = bus.wb_valid ? (NREG'(1) << bus.wb_rd) : '0;
  assign busy_eff = busy_q & ~wb_clr;
  assign stall    = bus.in_valid & ((use_rs1_p0 & busy_eff[rs1_p0]) |
                                    (use_rs2_p0 & busy_eff[rs2_p0]));
  assign in_ready = (!vld_p1 | bus.out_ready) & !stall & !bus.flush;
  assign accept   = bus.in_valid & in_ready;

  always_comb begin
    busy_nxt = busy_eff;
    // a flushed entry never issues, so its destination will never see a writeback
    if (bus.flush && vld_p1 && rd_p1 != '0) busy_nxt[rd_p1] = 1'b0;
    if (accept && rd_p0 != '0)              busy_nxt[rd_p0] = 1'b1;
    if (SCOREBOARD_EN == 0)                 busy_nxt = '0;
  end

  // ---- stage p1: output register ----
  always_ff @(posedge clock) begin
    if (reset) begin
      vld_p1    <= 1'b0;
      rs1_p1    <= '0;
      rs2_p1    <= '0;
      rd_p1     <= '0;
      imm_p1    <= '0;
      pc_p1     <= '0;
      pc_sel_p1 <= PC_PLUS_4;
      a_sel_p1  <= A_REG;
      b_sel_p1  <= B_REG;
      ill_p1    <= 1'b0;
      busy_q    <= '0;
    end else begin
      busy_q <= busy_nxt;
      if (accept) begin
        vld_p1    <= 1'b1;
        rs1_p1    <= rs1_p0;
        rs2_p1    <= rs2_p0;
        rd_p1     <= rd_p0;
        imm_p1    <= imm_p0;
        pc_p1     <= bus.in_pc;
        pc_sel_p1 <= pc_sel_p0;
        a_sel_p1  <= a_sel_p0;
        b_sel_p1  <= b_sel_p0;
        ill_p1    <= ill_p0;
      end else if (bus.out_ready || bus.flush) begin
        vld_p1 <= 1'b0;
      end
    end
  end

  assign bus.in_ready    = in_ready;
  assign bus.out_valid   = vld_p1;
  assign bus.out_rs1     = rs1_p1;
  assign bus.out_rs2     = rs2_p1;
  assign bus.out_rd      = rd_p1;
  assign bus.out_imm     = imm_p1;
  assign bus.out_pc      = pc_p1;
  assign bus.out_pc_sel  = pc_sel_p1;
  assign bus.out_a_sel   = a_sel_p1;
  assign bus.out_b_sel   = b_sel_p1;
  assign bus.out_illegal = ill_p1;
endmodule
